decode_out_capture: RTL and testbench
=====================================

# decode_out_capture

Parametrised, synthesizable capture engine for the LC3 decode-stage outputs. It samples the decode control/instruction bundle on every enabled clock edge and packs it into one word. Words are buffered in a show-ahead FIFO for the scoreboard/checker side to drain. It also provides end-of-test detection (enable rise-then-fall) and a watchdog timeout. It sits beside the decode DUT in the decode_out environment, replacing task-based sampling with a cycle-accurate, lossless-or-flagged buffer.

## Interface
- DATA_W, 16, width of Instr_Reg and npc_out; PKT_W = 9 + 2*DATA_W
- DEPTH, 8, FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 20000, watchdog limit in clock cycles; ≥1
- clock  in  1  sole clock, all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state
- en_de  in  1  decode enable; sample qualifier
- e_cntrl  in  6  execute control
- m_cntrl  in  1  memory control
- w_cntrl  in  2  writeback control
- Instr_Reg  in  DATA_W  instruction register
- npc_out  in  DATA_W  next PC
- change_only  in  1  1 = capture only when packed word differs from last sampled word
- rd_en  in  1  pop request
- rd_data  out  PKT_W  head entry, {e_cntrl, m_cntrl, w_cntrl, Instr_Reg, npc_out}
- rd_valid  out  1  FIFO non-empty
- count  out  $clog2(DEPTH+1)  occupancy
- overflow  out  1  sticky: a push was dropped
- drop_count  out  16  dropped pushes, saturates at 16'hFFFF
- stop  out  1  sticky end-of-test
- timeout  out  1  sticky watchdog expiry

## Operation
- FSM states: IDLE, ACTIVE, DONE, TIMEOUT.
  - IDLE→ACTIVE when en_de=1.
  - ACTIVE→DONE when en_de=0.
  - IDLE or ACTIVE→TIMEOUT when wd_cnt == TIMEOUT_CYCLES-1 at a clock edge.
  - DONE and TIMEOUT are terminal until reset.
- Watchdog:
  - wd_cnt increments every cycle in IDLE/ACTIVE and freezes in DONE/TIMEOUT.
  - If the DONE and TIMEOUT conditions hit on the same edge, DONE wins.
- Sample qualifier: en_de=1 and state ∈ {IDLE, ACTIVE}. The edge causing IDLE→ACTIVE samples.
  - en_de re-assertion after DONE is ignored: no capture, no state change.
- change_only=1: a qualified sample is pushed only if last_vld=0 or pkt≠last_pkt.
  - last_pkt/last_vld update on every qualified sample, including dropped ones.
  - change_only=0: every qualified sample is pushed.
- Push when full: word discarded, overflow←1, drop_count+1 (saturating). Exception: a pop on the same edge frees the slot, so the push succeeds.
- Pop: rd_en with rd_valid=1 advances head; rd_en when empty is ignored, with no error.
- Push+pop on empty: push occurs, pop ignored, count becomes 1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty derive from count.

## Timing
- Reset values:
  - rd_valid=0, count=0, overflow=0, drop_count=0, stop=0, timeout=0.
  - rd_data=0, state=IDLE, wd_cnt=0, last_vld=0.
- Reset asserted mid-run clears everything immediately (async); captured data is lost.
- Push latency 1: word sampled at edge k appears on rd_data with rd_valid=1 and count+1 after edge k when FIFO was empty.
- Show-ahead: rd_data is the head while rd_valid=1. After a pop at edge k, the next entry is visible after edge k.
- stop rises after the edge where en_de is sampled 0 in ACTIVE.
- timeout rises after the edge where wd_cnt == TIMEOUT_CYCLES-1.
- Outputs are registered or derived from registers only; no input-to-output combinational path.

## Structure
- Package decode_out_capture_pkg:
  - state enum (IDLE, ACTIVE, DONE, TIMEOUT).
  - pkt_w(DATA_W) function.
  - field offset localparams for unpacking e_cntrl/m_cntrl/w_cntrl/Instr_Reg/npc_out.
- Sub-module decode_out_sync_fifo (DEPTH, width PKT_W, show-ahead, count, full/empty). The top holds the FSM, watchdog, dedup compare and overflow accounting.

## Test plan
- Reset, then en_de=1 for 3 cycles with npc_out=0x3001,0x3002,0x3003, then 0 → three entries in order, stop=1 one cycle after en_de falls, timeout=0.
- DEPTH=8, 10 consecutive enabled samples, no pops → count=8, overflow=1, drop_count=2, and the first 8 words are intact.
- FIFO full, push and rd_en on the same edge → count stays 8, the new word is at the tail, drop_count unchanged.
- change_only=1, inputs held at Instr_Reg=0x1234 for 4 enabled cycles, then changed to 0x5678 → exactly 2 entries.
- TIMEOUT_CYCLES=50, en_de never asserted → timeout=1 after edge 50, and later en_de pulses capture nothing.
- Assert reset with 5 entries buffered and state ACTIVE → count=0, rd_valid=0, stop=0, state IDLE within the same cycle.

Source files
------------

// File: rtl/decode_out_capture_pkg.sv
// Shared types and packing layout for the LC3 decode-output capture engine.
package decode_out_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  localparam int E_CNTRL_W = 6;
  localparam int M_CNTRL_W = 1;
  localparam int W_CNTRL_W = 2;
  localparam int CTRL_W    = E_CNTRL_W + M_CNTRL_W + W_CNTRL_W;

  function automatic int pkt_w(input int data_w);
    return CTRL_W + 2 * data_w;
  endfunction

  // Packed word is {e_cntrl, m_cntrl, w_cntrl, Instr_Reg, npc_out}, LSB first from npc_out.
  function automatic int npc_off(input int data_w);
    return 0;
  endfunction

  function automatic int instr_off(input int data_w);
    return data_w;
  endfunction

  function automatic int w_cntrl_off(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int m_cntrl_off(input int data_w);
    return 2 * data_w + W_CNTRL_W;
  endfunction

  function automatic int e_cntrl_off(input int data_w);
    return 2 * data_w + W_CNTRL_W + M_CNTRL_W;
  endfunction

endpackage

// File: rtl/decode_out_capture_if.sv
// Decode-side sample bundle plus the drain-side read port of the capture engine.
interface decode_out_capture_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) ();
  localparam int PKT_W = decode_out_capture_pkg::pkt_w(DATA_W);
  localparam int CW    = $clog2(DEPTH + 1);

  logic              en_de;
  logic [5:0]        e_cntrl;
  logic              m_cntrl;
  logic [1:0]        w_cntrl;
  logic [DATA_W-1:0] Instr_Reg;
  logic [DATA_W-1:0] npc_out;
  logic              change_only;
  logic              rd_en;
  logic [PKT_W-1:0]  rd_data;
  logic              rd_valid;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [15:0]       drop_count;
  logic              stop;
  logic              timeout;

  modport master (
    output en_de, e_cntrl, m_cntrl, w_cntrl, Instr_Reg, npc_out, change_only, rd_en,
    input  rd_data, rd_valid, count, overflow, drop_count, stop, timeout
  );

  modport slave (
    input  en_de, e_cntrl, m_cntrl, w_cntrl, Instr_Reg, npc_out, change_only, rd_en,
    output rd_data, rd_valid, count, overflow, drop_count, stop, timeout
  );
endinterface

// File: rtl/decode_out_sync_fifo.sv
// Show-ahead synchronous FIFO; a full FIFO still accepts a push when popped on the same edge.
module decode_out_sync_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/decode_out_capture.sv
// Captures LC3 decode outputs into a show-ahead FIFO with dedup, overflow
// accounting, end-of-test detection and a watchdog.
module decode_out_capture
  import decode_out_capture_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input logic                 clock,
  input logic                 reset,
  decode_out_capture_if.slave bus
);
  localparam int PKT_W = pkt_w(DATA_W);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_cnt;
  logic              wd_hit;
  logic              running;
  logic              sample;
  logic [PKT_W-1:0]  pkt;
  logic [PKT_W-1:0]  last_pkt;
  logic              last_vld;
  logic              push_req;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [PKT_W-1:0]  fifo_rd_data;
  logic              overflow_q;
  logic [15:0]       drop_cnt_q;

  assign running = (state_q == IDLE) || (state_q == ACTIVE);
  assign wd_hit  = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign sample  = bus.en_de && running;

  always_comb begin
    pkt = '0;
    pkt[npc_off(DATA_W)     +: DATA_W]    = bus.npc_out;
    pkt[instr_off(DATA_W)   +: DATA_W]    = bus.Instr_Reg;
    pkt[w_cntrl_off(DATA_W) +: W_CNTRL_W] = bus.w_cntrl;
    pkt[m_cntrl_off(DATA_W) +: M_CNTRL_W] = bus.m_cntrl;
    pkt[e_cntrl_off(DATA_W) +: E_CNTRL_W] = bus.e_cntrl;
  end

  // End-of-test is checked before the watchdog so DONE wins a same-edge tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wd_hit)         state_d = TIMEOUT;
        else if (bus.en_de) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!bus.en_de)     state_d = DONE;
        else if (wd_hit)    state_d = TIMEOUT;
      end
      default:              state_d = state_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        wd_cnt <= '0;
    else if (running) wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_pkt <= '0;
      last_vld <= 1'b0;
    end else if (sample) begin
      last_pkt <= pkt;
      last_vld <= 1'b1;
    end
  end

  assign push_req = sample && (!bus.change_only || !last_vld || (pkt != last_pkt));
  // Full implies non-empty, so any rd_en on a full FIFO is a real pop.
  assign drop     = push_req && fifo_full && !bus.rd_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  decode_out_sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_req),
    .pop     (bus.rd_en),
    .wr_data (pkt),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.rd_data    = fifo_rd_data;
  assign bus.rd_valid   = !fifo_empty;
  assign bus.count      = fifo_count;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_cnt_q;
  assign bus.stop       = (state_q == DONE);
  assign bus.timeout    = (state_q == TIMEOUT);
endmodule

// File: tb/tb_decode_out_capture.sv
// Directed self-checking bench for decode_out_capture (DEPTH=8, TIMEOUT_CYCLES=50).
module tb_decode_out_capture;
  import decode_out_capture_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  decode_out_capture_if #(.DATA_W(16), .DEPTH(8)) bus ();

  decode_out_capture #(
    .DATA_W         (16),
    .DEPTH          (8),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] mk_pkt(input logic [5:0] e, input logic m, input logic [1:0] w,
                                         input logic [15:0] i, input logic [15:0] n);
    return {e, m, w, i, n};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    bus.en_de       = 1'b0;
    bus.e_cntrl     = '0;
    bus.m_cntrl     = 1'b0;
    bus.w_cntrl     = '0;
    bus.Instr_Reg   = '0;
    bus.npc_out     = '0;
    bus.change_only = 1'b0;
    bus.rd_en       = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit got=%0d exp=%0d", 1, 0);
    $fatal(1, "bench time limit");
  end

  initial begin
    // Basic three-sample run and end-of-test
    do_reset();
    check_eq("rst_rd_valid", bus.rd_valid, 0);
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_overflow", bus.overflow, 0);
    check_eq("rst_drop_count", bus.drop_count, 0);
    check_eq("rst_stop", bus.stop, 0);
    check_eq("rst_timeout", bus.timeout, 0);
    check_eq("rst_rd_data", bus.rd_data, 0);

    bus.en_de = 1'b1; bus.e_cntrl = 6'h2A; bus.m_cntrl = 1'b1; bus.w_cntrl = 2'b10;
    bus.Instr_Reg = 16'h1111; bus.npc_out = 16'h3001;
    tick();
    check_eq("t1_latency_valid", bus.rd_valid, 1);
    check_eq("t1_latency_count", bus.count, 1);
    check_eq("t1_head_pack", bus.rd_data, mk_pkt(6'h2A, 1'b1, 2'b10, 16'h1111, 16'h3001));
    bus.npc_out = 16'h3002; tick();
    bus.npc_out = 16'h3003; tick();
    check_eq("t1_stop_while_en", bus.stop, 0);
    bus.en_de = 1'b0; tick();
    check_eq("t1_stop", bus.stop, 1);
    check_eq("t1_timeout", bus.timeout, 0);
    check_eq("t1_count3", bus.count, 3);
    bus.en_de = 1'b1; tick(); bus.en_de = 1'b0;
    check_eq("t1_reassert_ignored", bus.count, 3);
    pop_one();
    check_eq("t1_second", bus.rd_data, mk_pkt(6'h2A, 1'b1, 2'b10, 16'h1111, 16'h3002));
    pop_one();
    check_eq("t1_third", bus.rd_data, mk_pkt(6'h2A, 1'b1, 2'b10, 16'h1111, 16'h3003));
    pop_one();
    check_eq("t1_drained_valid", bus.rd_valid, 0);
    pop_one();
    check_eq("t1_pop_empty_count", bus.count, 0);
    check_eq("t1_pop_empty_ovf", bus.overflow, 0);

    // Overflow: 10 samples into 8 entries
    do_reset();
    bus.en_de = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.npc_out = 16'(16'h0200 + i);
      tick();
    end
    bus.en_de = 1'b0;
    tick();
    check_eq("t2_count", bus.count, 8);
    check_eq("t2_overflow", bus.overflow, 1);
    check_eq("t2_drop_count", bus.drop_count, 2);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t2_word%0d", i), bus.rd_data, mk_pkt('0, 1'b0, '0, '0, 16'(16'h0200 + i)));
      pop_one();
    end
    check_eq("t2_empty", bus.rd_valid, 0);

    // Push and pop on the same edge while full
    do_reset();
    bus.en_de = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.npc_out = 16'(16'h0100 + i);
      tick();
    end
    check_eq("t3_full", bus.count, 8);
    bus.npc_out = 16'h01FF; bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0; bus.en_de = 1'b0;
    check_eq("t3_count_kept", bus.count, 8);
    check_eq("t3_drop_unchanged", bus.drop_count, 0);
    check_eq("t3_no_overflow", bus.overflow, 0);
    check_eq("t3_new_head", bus.rd_data, mk_pkt('0, 1'b0, '0, '0, 16'h0101));
    for (int i = 0; i < 7; i++) pop_one();
    check_eq("t3_tail", bus.rd_data, mk_pkt('0, 1'b0, '0, '0, 16'h01FF));

    // change_only dedup
    do_reset();
    bus.change_only = 1'b1; bus.en_de = 1'b1; bus.Instr_Reg = 16'h1234; bus.npc_out = 16'h3000;
    for (int i = 0; i < 4; i++) tick();
    bus.Instr_Reg = 16'h5678;
    tick();
    bus.en_de = 1'b0;
    tick();
    check_eq("t4_count", bus.count, 2);
    check_eq("t4_first", bus.rd_data, mk_pkt('0, 1'b0, '0, 16'h1234, 16'h3000));
    pop_one();
    check_eq("t4_second", bus.rd_data, mk_pkt('0, 1'b0, '0, 16'h5678, 16'h3000));

    // Watchdog expiry with en_de never asserted
    do_reset();
    for (int i = 0; i < 49; i++) tick();
    check_eq("t5_before_limit", bus.timeout, 0);
    tick();
    check_eq("t5_timeout", bus.timeout, 1);
    bus.en_de = 1'b1; bus.npc_out = 16'hBEEF;
    for (int i = 0; i < 3; i++) tick();
    bus.en_de = 1'b0;
    tick();
    check_eq("t5_no_capture", bus.count, 0);
    check_eq("t5_no_stop", bus.stop, 0);
    check_eq("t5_timeout_sticky", bus.timeout, 1);

    // Asynchronous reset mid-run
    do_reset();
    bus.en_de = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.npc_out = 16'(16'h0400 + i);
      tick();
    end
    check_eq("t6_pre_count", bus.count, 5);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_count", bus.count, 0);
    check_eq("t6_rd_valid", bus.rd_valid, 0);
    check_eq("t6_stop", bus.stop, 0);
    check_eq("t6_state_idle", dut.state_q == IDLE, 1);
    tick();
    reset = 1'b0;
    bus.npc_out = 16'h0500;
    tick();
    check_eq("t6_resume_count", bus.count, 1);
    check_eq("t6_resume_head", bus.rd_data, mk_pkt('0, 1'b0, '0, '0, 16'h0500));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
